// File: rtl/md_sequencer.sv
// Iterative RV32M multiply/divide sequencer (MUL, MULHU, DIVU, REMU) that
// borrows the core's shared 32-bit ALU for one add or subtract per cycle.
module md_sequencer #(
  parameter logic [3:0] SEL_ADD = 4'h0,
  parameter logic [3:0] SEL_SUB = 4'h1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_sel,
  input  logic [31:0] alu_out
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [1:0]  opq;
  logic [63:0] p, p_nxt;   // product {P}, or {R, Q} for divide
  logic [31:0] d;          // multiplicand or divisor
  logic [32:0] s;
  logic        carry;
  logic        accept, div0, is_mul, last;

  assign accept = in_valid & in_ready;
  assign div0   = op[1] & (rs2 == '0);
  assign is_mul = ~opq[1];
  assign last   = (cnt == 5'd31);
  assign s      = {p[63:32], p[31]};
  assign carry  = (alu_out < p[63:32]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept)                 state_nxt = div0 ? DONE : RUN;
      RUN:  if (last)                   state_nxt = DONE;
      DONE: if (out_valid && out_ready) state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
    busy     = (state != IDLE);
    alu_a    = '0;
    alu_b    = '0;
    alu_sel  = SEL_ADD;
    if (state == RUN) begin
      alu_b = d;
      if (is_mul) begin
        alu_a = p[63:32];
      end else begin
        alu_a   = s[31:0];
        alu_sel = SEL_SUB;
      end
    end
  end

  always_comb begin
    p_nxt = p;
    if (is_mul) begin
      if (p[0]) p_nxt = {carry, alu_out, p[31:1]};
      else      p_nxt = {1'b0, p[63:32], p[31:1]};
    end else begin
      if (s[32] || (s[31:0] >= d)) p_nxt = {alu_out, p[30:0], 1'b1};
      else                         p_nxt = {s[31:0], p[30:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      opq    <= '0;
      p      <= '0;
      d      <= '0;
      result <= '0;
    end else if (accept) begin
      opq <= op;
      cnt <= '0;
      if (op[1]) begin
        p <= {32'h0, rs1};
        d <= rs2;
      end else begin
        p <= {32'h0, rs2};
        d <= rs1;
      end
      if (div0) result <= op[0] ? rs1 : '1;
    end else if (state == RUN) begin
      p   <= p_nxt;
      cnt <= cnt + 5'd1;
      if (last) begin
        case (opq)
          2'd0:    result <= p_nxt[31:0];
          2'd1:    result <= p_nxt[63:32];
          2'd2:    result <= p_nxt[31:0];
          default: result <= p_nxt[63:32];
        endcase
      end
    end
  end

  // Result is presented one edge after DONE is entered and withdrawn on the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          out_valid <= 1'b0;
    else if (out_valid && out_ready)  out_valid <= 1'b0;
    else if (state == DONE)           out_valid <= 1'b1;
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: directed cases, randomized operations
// against an arithmetic reference model, output hold, and mid-operation reset.
module tb_md_sequencer;

  localparam logic [3:0] SEL_ADD = 4'h0;
  localparam logic [3:0] SEL_SUB = 4'h1;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] rs1, rs2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_sel;

  int vectors = 0;
  int miscompares = 0;

  md_sequencer #(.SEL_ADD(SEL_ADD), .SEL_SUB(SEL_SUB)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rs1(rs1), .rs2(rs2),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out)
  );

  always #5 clk = ~clk;

  // Shared ALU stand-in; unknown selects yield a poison value.
  assign alu_out = (alu_sel == SEL_ADD) ? alu_a + alu_b :
                   (alu_sel == SEL_SUB) ? alu_a - alu_b : 32'hDEADBEEF;

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    prod = 64'(a) * 64'(b);
    case (o)
      2'd0:    return prod[31:0];
      2'd1:    return prod[63:32];
      2'd2:    return (b == 0) ? 32'hFFFFFFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issues one request, scrambles inputs after acceptance, waits for out_valid.
  // lat = edges after the accept edge until out_valid seen; selbad counts
  // RUN-window samples with the wrong ALU select.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit collect, output logic [31:0] res, output int lat,
                       output int selbad, output bit tout);
    logic [3:0] exp_sel;
    bit dz;
    dz = o[1] && (b == 0);
    exp_sel = (dz || !o[1]) ? SEL_ADD : SEL_SUB;
    in_valid = 1'b1; op = o; rs1 = a; rs2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 2'($urandom); rs1 = $urandom; rs2 = $urandom;
    lat = 0; selbad = 0; tout = 1'b0;
    while (!out_valid) begin
      if (lat < 32 && !dz && alu_sel !== exp_sel) selbad++;
      @(posedge clk); #1;
      lat++;
      if (lat > 100) begin
        tout = 1'b1;
        break;
      end
    end
    res = result;
    if (collect && !tout) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; op = '0; rs1 = '0; rs2 = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({in_ready, out_valid, busy, result, alu_a, alu_b, alu_sel} !==
        {1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, SEL_ADD}) begin
      miscompares++;
      $display("FAIL reset_state: ir=%b ov=%b busy=%b res=%h a=%h b=%h sel=%h, want 1 0 0 0 0 0 %h",
               in_ready, out_valid, busy, result, alu_a, alu_b, alu_sel, SEL_ADD);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      miscompares++;
      $display("FAIL post_reset_idle: ir=%b ov=%b busy=%b, want 1 0 0", in_ready, out_valid, busy);
    end
  endtask

  task automatic test_directed();
    logic [1:0]  t_op  [9] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd3, 2'd2, 2'd3, 2'd2, 2'd3};
    logic [31:0] t_a   [9] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd100, 32'd100,
                               32'hFFFFFFFF, 32'd5, 32'h12345678, 32'd123};
    logic [31:0] t_b   [9] = '{32'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'd7,
                               32'd1, 32'h80000000, 32'd0, 32'd0};
    logic [31:0] t_exp [9] = '{32'd42, 32'hFFFFFFFE, 32'h00000001, 32'd14, 32'd2,
                               32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'd123};
    int          t_lat [9] = '{33, 33, 33, 33, 33, 33, 33, 1, 1};
    logic [31:0] res;
    int lat, selbad;
    bit tout;
    for (int i = 0; i < 9; i++) begin
      do_op(t_op[i], t_a[i], t_b[i], 1'b1, res, lat, selbad, tout);
      vectors++;
      if (tout || res !== t_exp[i]) begin
        miscompares++;
        $display("FAIL directed_result[%0d]: got %h (timeout=%0b), want %h", i, res, tout, t_exp[i]);
      end
      vectors++;
      if (lat != t_lat[i] || selbad != 0) begin
        miscompares++;
        $display("FAIL directed_timing[%0d]: latency %0d bad_sel %0d, want latency %0d bad_sel 0",
                 i, lat, selbad, t_lat[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] a, b, res;
    int lat, selbad, explat;
    bit tout;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'h0;
        1:       b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      explat = (o[1] && b == 0) ? 1 : 33;
      do_op(o, a, b, 1'b1, res, lat, selbad, tout);
      vectors++;
      if (tout || res !== model(o, a, b) || lat != explat || selbad != 0) begin
        miscompares++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h lat %0d badsel %0d, want %h lat %0d",
                 i, o, a, b, res, lat, selbad, model(o, a, b), explat);
      end
    end
  endtask

  task automatic test_hold();
    logic [31:0] res, held;
    int lat, selbad, bad;
    bit tout;
    do_op(2'd2, 32'd1000, 32'd9, 1'b0, held, lat, selbad, tout);
    vectors++;
    if (tout || held !== 32'd111) begin
      miscompares++;
      $display("FAIL hold_first: got %h, want %h", held, 32'd111);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom); op = 2'($urandom); rs1 = $urandom; rs2 = $urandom;
      @(posedge clk); #1;
      if (!out_valid || result !== held || in_ready || !busy) bad++;
    end
    in_valid = 1'b0;
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL hold_stable: %0d bad cycles, want 0", bad);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    vectors++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      miscompares++;
      $display("FAIL hold_release: ir=%b ov=%b busy=%b, want 1 0 0", in_ready, out_valid, busy);
    end
    do_op(2'd1, 32'h80000000, 32'h00000006, 1'b1, res, lat, selbad, tout);
    vectors++;
    if (res !== 32'h3 || lat != 33) begin
      miscompares++;
      $display("FAIL hold_next: got %h lat %0d, want 00000003 lat 33", res, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res;
    int lat, selbad;
    bit tout;
    do_op(2'd0, 32'd9, 32'd9, 1'b0, res, lat, selbad, tout);
    out_ready = 1'b1; in_valid = 1'b1; op = 2'd0; rs1 = 32'd2; rs2 = 32'd2;
    @(posedge clk); #1;
    out_ready = 1'b0;
    vectors++;
    if ({in_ready, busy, out_valid} !== 3'b100) begin
      miscompares++;
      $display("FAIL b2b_handshake: ir=%b busy=%b ov=%b, want 1 0 0", in_ready, busy, out_valid);
    end
    in_valid = 1'b0;
    do_op(2'd3, 32'd77, 32'd10, 1'b1, res, lat, selbad, tout);
    vectors++;
    if (res !== 32'd7 || lat != 33) begin
      miscompares++;
      $display("FAIL b2b_next: got %h lat %0d, want 00000007 lat 33", res, lat);
    end
  endtask

  task automatic test_midrun_reset();
    logic [31:0] res;
    int lat, selbad;
    bit tout;
    in_valid = 1'b1; op = 2'd0; rs1 = 32'hABCDEF01; rs2 = 32'h12345;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    vectors++;
    if ({in_ready, out_valid, busy, result, alu_a, alu_b, alu_sel} !==
        {1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, SEL_ADD}) begin
      miscompares++;
      $display("FAIL midrun_reset: ir=%b ov=%b busy=%b res=%h a=%h b=%h sel=%h, want 1 0 0 0 0 0 %h",
               in_ready, out_valid, busy, result, alu_a, alu_b, alu_sel, SEL_ADD);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    do_op(2'd0, 32'd3, 32'd5, 1'b1, res, lat, selbad, tout);
    vectors++;
    if (res !== 32'd15 || lat != 33 || selbad != 0) begin
      miscompares++;
      $display("FAIL after_reset_mul: got %h lat %0d badsel %0d, want 0000000f lat 33", res, lat, selbad);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_back_to_back();
    test_midrun_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
